// File: rtl/gpio_in_cond.sv
// gpio_in_cond: per-pin input conditioning for GPIO pad read-back.
//   Each pin: SYNC_STAGES-deep metastability synchronizer -> debounce filter
//   with shared threshold -> rise/fall strobes -> sticky pending bit.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   pad_in[N_PINS]          raw pad values (asynchronous to clk)
//   deb_cycles[DEB_W]       debounce threshold, 0 treated as 1
//   ie_rise/ie_fall[N_PINS] per-pin edge interrupt enables
//   irq_clear[N_PINS]       write-1-to-clear pulse for pending bits
//   in_val[N_PINS]          debounced pin value
//   irq_pending[N_PINS]     sticky pending bits
//   irq_o                   OR of pending bits, registered

// One pin's worth of conditioning; instantiated N_PINS times by the top.
module gpio_in_cond_pin #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pad,
  input  logic [DEB_W-1:0] deb_cycles,
  input  logic             ie_rise,
  input  logic             ie_fall,
  input  logic             irq_clear,
  output logic             in_val,
  output logic             pend,
  output logic             pend_nxt
);
  localparam logic [DEB_W-1:0] ONE     = {{(DEB_W-1){1'b0}}, 1'b1};
  localparam logic [DEB_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       cnt_q, cnt_d;
  logic [DEB_W-1:0]       deb_lim;
  logic                   val_q, val_d;
  logic                   val_dly_q, val_dly_d;
  logic                   pend_q, pend_d;
  logic                   s, rise, fall;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pad};
    // Deff-1 with Deff = max(deb_cycles,1); uses the live threshold so a
    // lowered value takes effect on the very next edge.
    deb_lim   = (deb_cycles == '0) ? '0 : deb_cycles - ONE;
    val_d     = val_q;
    cnt_d     = '0;
    if (s != val_q) begin
      if (cnt_q >= deb_lim) begin
        val_d = s;
        cnt_d = '0;
      end else begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;
      end
    end
    val_dly_d = val_q;
    rise      = val_q & ~val_dly_q;
    fall      = ~val_q & val_dly_q;
    // Set beats clear so an event arriving with a clear pulse is kept.
    pend_d    = (pend_q & ~irq_clear) | (rise & ie_rise) | (fall & ie_fall);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      val_q     <= 1'b0;
      val_dly_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      val_q     <= val_d;
      val_dly_q <= val_dly_d;
      pend_q    <= pend_d;
    end
  end

  assign in_val   = val_q;
  assign pend     = pend_q;
  assign pend_nxt = pend_d;
endmodule

module gpio_in_cond #(
  parameter int N_PINS      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_PINS-1:0] pad_in,
  input  logic [DEB_W-1:0]  deb_cycles,
  input  logic [N_PINS-1:0] ie_rise,
  input  logic [N_PINS-1:0] ie_fall,
  input  logic [N_PINS-1:0] irq_clear,
  output logic [N_PINS-1:0] in_val,
  output logic [N_PINS-1:0] irq_pending,
  output logic              irq_o
);
  logic [N_PINS-1:0] pend_nxt;
  logic              irq_q, irq_d;

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    gpio_in_cond_pin #(.SYNC_STAGES(SYNC_STAGES), .DEB_W(DEB_W)) u_pin (
      .clk        (clk),
      .reset_n    (reset_n),
      .pad        (pad_in[i]),
      .deb_cycles (deb_cycles),
      .ie_rise    (ie_rise[i]),
      .ie_fall    (ie_fall[i]),
      .irq_clear  (irq_clear[i]),
      .in_val     (in_val[i]),
      .pend       (irq_pending[i]),
      .pend_nxt   (pend_nxt[i])
    );
  end

  // Registered copy of |irq_pending so the irq line is glitch-free;
  // it tracks the pending OR cycle for cycle.
  always_comb irq_d = |pend_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq_o = irq_q;
endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: scoreboard bench. The driver applies inputs just after each
// falling edge and pushes the reference model's expected outputs for the next
// rising edge; the monitor pops and compares on the following falling edge.
module tb_gpio_in_cond;
  localparam int N    = 32;
  localparam int SYNC = 2;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [N-1:0]  pad_in = '0, ie_rise = '0, ie_fall = '0, irq_clear = '0;
  logic [DW-1:0] deb_cycles = '0;
  logic [N-1:0]  in_val, irq_pending;
  logic          irq_o;

  gpio_in_cond #(.N_PINS(N), .SYNC_STAGES(SYNC), .DEB_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .pad_in(pad_in), .deb_cycles(deb_cycles),
    .ie_rise(ie_rise), .ie_fall(ie_fall), .irq_clear(irq_clear),
    .in_val(in_val), .irq_pending(irq_pending), .irq_o(irq_o));

  always #5 clk = ~clk;

  // next-cycle stimulus
  logic          n_rst = 1'b0;
  logic [N-1:0]  n_pad = '0, n_ier = '0, n_ief = '0, n_clr = '0;
  logic [DW-1:0] n_deb = '0;

  typedef struct packed {
    logic [N-1:0] v;
    logic [N-1:0] p;
    logic         irq;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_err = 0;

  function automatic void chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: pad history delayed SYNC edges, then a per-pin run-length
  // of how long the synchronized value has disagreed with the output.
  logic [N-1:0] m_hist[SYNC];
  logic [N-1:0] m_val, m_prev, m_pend;
  int           m_run[N];

  task automatic model_step();
    logic [N-1:0] s, nv, rise, fall;
    int deff;
    if (!n_rst) begin
      for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
      m_val = '0; m_prev = '0; m_pend = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      s    = m_hist[SYNC-1];
      deff = (n_deb == 0) ? 1 : int'(n_deb);
      nv   = m_val;
      for (int i = 0; i < N; i++) begin
        if (s[i] == m_val[i]) m_run[i] = 0;
        else if (m_run[i] + 1 >= deff) begin nv[i] = s[i]; m_run[i] = 0; end
        else if (m_run[i] < 255) m_run[i] = m_run[i] + 1;
      end
      rise   = m_val & ~m_prev;
      fall   = ~m_val & m_prev;
      m_pend = (m_pend & ~n_clr) | (rise & n_ier) | (fall & n_ief);
      m_prev = m_val;
      m_val  = nv;
      for (int k = SYNC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = n_pad;
    end
    exp_q.push_back('{v: m_val, p: m_pend, irq: (m_pend != '0)});
  endtask

  // Apply one cycle of stimulus and record the expectation for the next edge.
  task automatic cyc();
    @(negedge clk); #1;
    reset_n = n_rst; pad_in = n_pad; deb_cycles = n_deb;
    ie_rise = n_ier; ie_fall = n_ief; irq_clear = n_clr;
    model_step();
  endtask

  task automatic cycn(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_in_val", in_val, e.v);
      chk("sb_irq_pending", irq_pending, e.p);
      chk("sb_irq_o", {{(N-1){1'b0}}, irq_o}, {{(N-1){1'b0}}, e.irq});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    // reset with pads toggling: everything must read zero
    n_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin n_pad = $urandom; cyc(); end
    chk("rst_in_val", in_val, '0);
    chk("rst_pend", irq_pending, '0);
    chk("rst_irq", {31'b0, irq_o}, '0);

    // minimum debounce latency and interrupt timing on pin 3
    n_pad = '0; n_rst = 1'b1; n_deb = '0; n_ier = 32'h8;
    cycn(4);
    n_pad[3] = 1'b1;
    cycn(3);
    chk("lat_in_val3_e2", {31'b0, in_val[3]}, 32'h0);
    cyc();
    chk("lat_in_val3_e3", {31'b0, in_val[3]}, 32'h1);
    chk("lat_pend3_e3", {31'b0, irq_pending[3]}, 32'h0);
    cyc();
    chk("lat_pend3_e4", {31'b0, irq_pending[3]}, 32'h1);
    chk("lat_irq_e4", {31'b0, irq_o}, 32'h1);
    n_clr = '1; cyc(); n_clr = '0; n_ier = '0; cyc();

    // glitch of 4 cycles is filtered with deb=5; 5 cycles passes at edge 7
    n_deb = 8'd5; n_ier = 32'h1;
    n_pad[0] = 1'b1; cycn(4);
    n_pad[0] = 1'b0; cycn(10);
    chk("glitch_in_val0", {31'b0, in_val[0]}, 32'h0);
    chk("glitch_pend0", {31'b0, irq_pending[0]}, 32'h0);
    n_pad[0] = 1'b1; cycn(7);
    chk("deb5_e6", {31'b0, in_val[0]}, 32'h0);
    cyc();
    chk("deb5_e7", {31'b0, in_val[0]}, 32'h1);
    cycn(2);
    chk("deb5_pend0", {31'b0, irq_pending[0]}, 32'h1);
    n_clr = '1; cyc(); n_clr = '0; n_ier = '0; cyc();

    // falling edge interrupt on pin 7, clear, clear racing a new event
    n_deb = '0; n_ief = 32'h80;
    n_pad[7] = 1'b1; cycn(6);
    n_pad[7] = 1'b0; cycn(6);
    chk("fall_pend7", {31'b0, irq_pending[7]}, 32'h1);
    n_clr[7] = 1'b1; cyc(); n_clr = '0; cyc();
    chk("clr_pend7", {31'b0, irq_pending[7]}, 32'h0);
    chk("clr_irq", {31'b0, irq_o}, 32'h0);
    n_pad[7] = 1'b1; cycn(6);
    n_pad[7] = 1'b0; cycn(3);
    n_clr[7] = 1'b1; cyc(); n_clr = '0; cyc();
    chk("race_pend7", {31'b0, irq_pending[7]}, 32'h1);
    n_clr = '1; cyc(); n_clr = '0; n_ief = '0; cyc();

    // enables off: value follows, nothing pends; then enable rise on pin 5
    n_deb = 8'd2;
    n_pad[5] = 1'b1; cycn(8);
    chk("noie_val5_hi", {31'b0, in_val[5]}, 32'h1);
    n_pad[5] = 1'b0; cycn(8);
    chk("noie_val5_lo", {31'b0, in_val[5]}, 32'h0);
    chk("noie_pend", irq_pending, '0);
    n_ier = 32'h20; n_pad[5] = 1'b1; cycn(8);
    chk("ie_pend5", {31'b0, irq_pending[5]}, 32'h1);

    // randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      n_pad = n_pad ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) n_deb = DW'($urandom_range(0, 6));
      if ($urandom_range(0, 63) == 0) n_ier = $urandom;
      if ($urandom_range(0, 63) == 0) n_ief = $urandom;
      n_clr = ($urandom_range(0, 7) == 0) ? ($urandom & $urandom) : '0;
      n_rst = ($urandom_range(0, 199) != 0);
      cyc();
    end
    n_rst = 1'b1; n_clr = '0;
    cycn(3);
    @(negedge clk); #2;
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
